// File: rtl/piso_sb_tx.sv
// LSB-first parallel-in serial-out transmitter with ready/valid load, sof/eof strobes and back-to-back framing.
// Optional trailing even-parity bit is enabled by defining PISO_SB_PARITY_EN.
module piso_sb_tx #(
  parameter int WIDTH = 384,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             eof,
  output logic             o_dbg_state
);

  // Handshake: a word is taken on a rising edge where load_valid, load_ready and en are all high.
  // load_ready depends only on registered state, so upstream may use it combinationally.
`ifdef PISO_SB_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_accept;
`ifdef PISO_SB_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
  logic             w_par_slot;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
`ifdef PISO_SB_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef PISO_SB_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign w_accept = en && load_valid && load_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
`ifdef PISO_SB_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_accept) begin
      // Covers both the idle load and the seamless reload on a frame's final bit.
      w_state_nxt = S_SHIFT;
      w_shreg_nxt = din;
      w_cnt_nxt   = '0;
`ifdef PISO_SB_PARITY_EN
      w_par_nxt   = ^din;
`endif
    end else if (en && (r_state == S_SHIFT)) begin
      w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PISO_SB_PARITY_EN
  assign w_par_slot = (r_cnt == CNT_W'(WIDTH));
`endif

  always_comb begin
    load_ready = (r_state == S_IDLE) || w_last;
    dout_valid = (r_state == S_SHIFT);
    sof        = (r_state == S_SHIFT) && (r_cnt == '0);
    eof        = w_last;
`ifdef PISO_SB_PARITY_EN
    dout       = (r_state == S_SHIFT) && (w_par_slot ? r_par : r_shreg[0]);
`else
    dout       = (r_state == S_SHIFT) && r_shreg[0];
`endif
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_piso_sb_tx.sv
// Self-checking bench for piso_sb_tx: reset, single frame, back-to-back, stall, mid-frame reset, parity.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_piso_sb_tx;
  localparam int W = 384;
`ifdef PISO_SB_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  logic         clk = 1'b0;
  logic         res;
  logic         en;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] din;
  logic         dout;
  logic         dout_valid;
  logic         sof;
  logic         eof;
  logic         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  piso_sb_tx #(.WIDTH(W), .CNT_W(9)) dut (
    .clk(clk), .res(res), .en(en), .load_valid(load_valid), .load_ready(load_ready),
    .din(din), .dout(dout), .dout_valid(dout_valid), .sof(sof), .eof(eof),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: bit k of a frame is word[k]; the optional trailing bit is the word's XOR.
  function automatic logic frame_bit(input logic [W-1:0] word, input int k);
    if (k < W) return word[k];
    return ^word;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic test_reset();
    res = 1'b1; en = 1'b0; load_valid = 1'b0; din = '0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin res = 1'b0; en = 1'b1; end
      @(negedge clk);
      checks++;
      if ({dout, dout_valid, sof, eof, load_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got dout/vld/sof/eof/rdy=%b%b%b%b%b exp 00001",
                 c, dout, dout_valid, sof, eof, load_ready);
      end
    end
  endtask

  // One frame; optional stall of stall_len cycles after bit stall_at is shown.
  task automatic test_single_frame(input logic [W-1:0] word, input string name,
                                   input int stall_at, input int stall_len);
    logic [W-1:0] rx;
    int vcycles;
    rx = '0; vcycles = 0;
    din = word; load_valid = 1'b1; en = 1'b1;
    exp_q.push_back(word);
    @(negedge clk);
    load_valid = 1'b0;
    din = rand_word();
    for (int k = 0; k < L; k++) begin
      for (int s = 0; s <= ((k == stall_at) ? stall_len : 0); s++) begin
        vcycles += dout_valid ? 1 : 0;
        checks++;
        if ({dout, dout_valid, sof, eof, load_ready} !==
            {frame_bit(word, k), 1'b1, k == 0, k == L - 1, k == L - 1}) begin
          errors++;
          $display("FAIL %s_bit k=%0d s=%0d got dout/vld/sof/eof/rdy=%b%b%b%b%b exp %b1%b%b%b",
                   name, k, s, dout, dout_valid, sof, eof, load_ready,
                   frame_bit(word, k), k == 0, k == L - 1, k == L - 1);
        end
        en = !((k == stall_at) && (s < stall_len));
        if (en && k < W) rx = {dout, rx[W-1:1]};
        @(negedge clk);
      end
    end
    checks++;
    if ({dout, dout_valid, sof, eof, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL %s_idle got dout/vld/sof/eof/rdy=%b%b%b%b%b exp 00001",
               name, dout, dout_valid, sof, eof, load_ready);
    end
    checks++;
    if (vcycles !== L + ((stall_at >= 0) ? stall_len : 0)) begin
      errors++;
      $display("FAIL %s_length got %0d exp %0d", name, vcycles,
               L + ((stall_at >= 0) ? stall_len : 0));
    end
    begin
      logic [W-1:0] exp_w;
      exp_w = exp_q.pop_front();
      checks++;
      if (rx !== exp_w) begin
        errors++;
        $display("FAIL %s_rx_word got %h exp %h", name, rx, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back(input logic [W-1:0] w1, input logic [W-1:0] w2);
    logic [W-1:0] rx;
    logic [W-1:0] cur;
    en = 1'b1; din = w1; load_valid = 1'b1;
    exp_q.push_back(w1); exp_q.push_back(w2);
    @(negedge clk);
    din = w2;
    for (int f = 0; f < 2; f++) begin
      cur = (f == 0) ? w1 : w2;
      rx = '0;
      for (int k = 0; k < L; k++) begin
        checks++;
        if ({dout, dout_valid, sof, eof, load_ready} !==
            {frame_bit(cur, k), 1'b1, k == 0, k == L - 1, k == L - 1}) begin
          errors++;
          $display("FAIL b2b_bit f=%0d k=%0d got dout/vld/sof/eof/rdy=%b%b%b%b%b exp %b1%b%b%b",
                   f, k, dout, dout_valid, sof, eof, load_ready,
                   frame_bit(cur, k), k == 0, k == L - 1, k == L - 1);
        end
        if (k < W) rx = {dout, rx[W-1:1]};
        if (f == 1) load_valid = 1'b0;
        @(negedge clk);
      end
      begin
        logic [W-1:0] exp_w;
        exp_w = exp_q.pop_front();
        checks++;
        if (rx !== exp_w) begin
          errors++;
          $display("FAIL b2b_rx_word f=%0d got %h exp %h", f, rx, exp_w);
        end
      end
    end
    checks++;
    if ({dout_valid, load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle got vld/rdy=%b%b exp 01", dout_valid, load_ready);
    end
  endtask

  task automatic test_mid_reset(input logic [W-1:0] word);
    en = 1'b1; din = word; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 200; k++) @(negedge clk);
    checks++;
    if ({dout, dout_valid} !== {word[200], 1'b1}) begin
      errors++;
      $display("FAIL midrst_bit200 got dout/vld=%b%b exp %b1", dout, dout_valid, word[200]);
    end
    #2 res = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, sof, eof, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_async got dout/vld/sof/eof/rdy=%b%b%b%b%b exp 00001",
               dout, dout_valid, sof, eof, load_ready);
    end
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout_valid, load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_no_resume got vld/rdy=%b%b exp 01", dout_valid, load_ready);
    end
    test_single_frame(rand_word(), "midrst_restart", -1, 0);
  endtask

`ifdef PISO_SB_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w7;
    logic [W-1:0] w8;
    w7 = '0; w8 = '0;
    for (int i = 0; i < 7; i++) w7[i * 50] = 1'b1;
    for (int i = 0; i < 8; i++) w8[i * 47 + 3] = 1'b1;
    test_single_frame(w7, "parity_odd", -1, 0);
    test_single_frame(w8, "parity_even", -1, 0);
  endtask
`endif

  initial begin
    logic [W-1:0] w;
    test_reset();
    w = rand_word();
    w[W-1:W-16] = 16'h3A7B;
    w[15:0] = 16'h66E2;
    test_single_frame(w, "single", -1, 0);
    test_single_frame(rand_word(), "single_rand", -1, 0);
    test_back_to_back(rand_word(), {{(W-1){1'b0}}, 1'b1});
    test_single_frame(rand_word(), "stall", 100, 5);
    test_single_frame(rand_word(), "stall_rand", $urandom_range(1, L - 2), $urandom_range(1, 8));
    test_mid_reset(rand_word());
`ifdef PISO_SB_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_sb_tx.md
# piso_sb_tx

Parallel-in serial-out transmitter that loads a WIDTH-bit word and serialises it LSB-first, one bit per enabled clock. It is the companion of the SIPO_SB shift-register receiver: its `dout` bit stream drives the receiver's `din` directly. It adds a ready/valid load handshake, a bit counter, frame-boundary strobes and back-to-back framing.

## Interface
- `WIDTH`, default 384: bits per word. Must be ≥ 2.
- `CNT_W`, default 9: bit-counter width. Must satisfy 2^CNT_W ≥ WIDTH+1.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `res`  in  1: asynchronous, active-high reset.
- `en`  in  1: shift enable. When low, all state is frozen.
- `load_valid`  in  1: `din` holds a word to transmit.
- `load_ready`  out  1: the block can accept a word this cycle.
- `din`  in  WIDTH: parallel word. Bit 0 is transmitted first.
- `dout`  out  1: serial data bit.
- `dout_valid`  out  1: `dout` carries a frame bit this cycle.
- `sof`  out  1: marks the first bit of a frame.
- `eof`  out  1: marks the last bit of a frame.

## Operation
- Reset values: `dout`=0, `dout_valid`=0, `sof`=0, `eof`=0, `load_ready`=1, shift register=0, counter=0, state=IDLE.
- Load is accepted when `load_valid` & `load_ready` & `en` are all high at a rising edge. `din` is captured at that edge.
- State IDLE:
  - `load_ready`=1, `dout_valid`=0, `dout`=0.
  - On accept: go to SHIFT with counter=0.
- State SHIFT:
  - `dout` = shreg[0], `dout_valid`=1.
  - `sof`=1 when counter==0.
  - `eof`=1 on the final frame bit.
  - Each enabled edge: shift right by 1 (shreg <= {1'b0, shreg[WIDTH-1:1]}), then counter+1.
- Frame length (L): WIDTH bits, or WIDTH+1 when parity is enabled (see Configuration).
- `load_ready` in SHIFT is asserted only on the final bit (counter==L-1). This allows back-to-back frames.
  - Accept on the final bit: reload `din`, counter=0, stay in SHIFT. The next cycle shows `sof` with no gap.
  - Final bit without an accept: return to IDLE.
- `load_valid` while not ready has no effect. The upstream must hold `din` until it is accepted.
- `en`=0:
  - Registers hold and no load is accepted. `load_ready` still reflects the state.
  - Outputs keep their values, so the stall is transparent to a receiver that is gated by the same `en`.
- `res` asserted mid-frame: the frame is aborted immediately. No partial word resumes after reset is released.
- Counter never exceeds L-1. No wrap-around within a frame.

## Timing
- Latency: accept at edge N puts bit 0 on `dout` after edge N. Bit k is valid in cycle N+1+k when `en` stays high.
- Frame occupies L consecutive enabled cycles. Back-to-back throughput is 1 bit per enabled cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs, including `load_ready`.
- `sof` and `eof` are each 1 cycle wide per frame.
- A receiver sampling on the same edges with the same `en` captures bit k at the edge ending cycle N+1+k.

## Configuration
- Macro `PISO_SB_PARITY_EN`.
- Defined:
  - L = WIDTH+1. After data bit WIDTH-1, one extra bit is sent: the even parity (XOR) of the captured word.
  - `eof` marks the parity bit instead of data bit WIDTH-1.
  - Parity is computed at load time and stored in a 1-bit register, which resets to 0.
- Undefined: L = WIDTH. No parity logic is present.

## Test plan
- Reset then idle: `res`=1 for 3 cycles, then `res`=0 with `load_valid`=0 → `dout`=0, `dout_valid`=0, `load_ready`=1 throughout.
- Single frame with `din`=384'h3A7B…66E2 and `en`=1 → 384 bits appear LSB-first. `sof` on cycle 1, `eof` on cycle 384, then return to IDLE. A SIPO_SB fed by `dout` ends with `dout`=3A7B…66E2.
- Back-to-back: a second word 384'h0…01 is held valid during the first frame → accepted on the first frame's `eof` cycle. Next cycle has `sof`=1 and `dout`=1, with zero idle cycles between frames.
- Stall: `en`=0 for 5 cycles at bit 100 → `dout`, `dout_valid` and the counter hold. Bit 101 follows once `en` returns high. Total frame length is 389 cycles.
- Mid-frame reset: `res` pulsed at bit 200 → outputs go to 0 and `load_ready`=1 asynchronously. A new load restarts from bit 0.
- With `PISO_SB_PARITY_EN`: `din` has 7 ones → a 385th bit equal to 1 is sent with `eof`. With 8 ones, the 385th bit is 0.
